// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, state encoding and overflow helper for the nibble-serial adder
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow: carry out of the MSB differs from the carry into it.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic c_out);
    logic c_in_msb;
    c_in_msb = a_msb ^ b_msb ^ s_msb;
    return c_out ^ c_in_msb;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// rtl/nibble_serial_adder_ctrl_slice.sv - 4-bit ripple-carry adder slice
module nibble_serial_adder_ctrl_slice (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] c;

  always_comb begin
    c    = 5'b0;
    Sum  = 4'b0;
    c[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      Sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end
    Cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit add/subtract sequenced over one 4-bit adder slice
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_sh, b_sh, sum_r;
  logic [CNT_W-1:0]  cnt;
  logic              carry, cout_r, ovf_r;
  logic [3:0]        slice_sum;
  logic              slice_cout;
  logic              accept, last;

  nibble_serial_adder_ctrl_slice u_slice (
    .A    (a_sh[NIBBLE_W-1:0]),
    .B    (b_sh[NIBBLE_W-1:0]),
    .Cin  (carry),
    .Sum  (slice_sum),
    .Cout (slice_cout)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        last = (cnt == CNT_LAST);
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      // Result nibbles enter at the top so the LS nibble lands at bit 0 after the final pass.
      sum_r <= {slice_sum, sum_r[WIDTH-1:NIBBLE_W]};
      a_sh  <= a_sh >> NIBBLE_W;
      b_sh  <= b_sh >> NIBBLE_W;
      carry <= slice_cout;
      cnt   <= last ? '0 : cnt + CNT_W'(1);
      if (last) begin
        cout_r <= slice_cout;
        ovf_r  <= signed_ovf(a_sh[3], b_sh[3], slice_sum[3], slice_cout);
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - randomized self-checking bench for nibble_serial_adder_ctrl
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;
  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout, ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    int unsigned ua, ub, full;
    ua = ma;
    ub = mb;
    if (msub) begin
      full = ua + (32'h1_0000 - ub);
      es = W'(full);
      ec = (ua >= ub);
      eo = (ma[W-1] != mb[W-1]) && (es[W-1] != ma[W-1]);
    end else begin
      full = ua + ub;
      es = W'(full);
      ec = full[W];
      eo = (ma[W-1] == mb[W-1]) && (es[W-1] != ma[W-1]);
    end
  endtask

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub,
                        input int hold, input bit disturb);
    logic [W-1:0] es;
    logic ec, eo;
    int lat;
    model(oa, ob, osub, es, ec, eo);
    check("in_ready_before_accept", in_ready, 1);
    a = oa; b = ob; sub = osub; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    if (disturb) begin
      a = W'($urandom); b = W'($urandom); sub = ~osub;
    end else begin
      in_valid = 1'b0;
    end
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) in_valid = 1'b0;
      if (!out_valid) check("in_ready_busy", in_ready, 0);
    end
    check("latency", lat, LAT);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, es);
      @(posedge clk); #1;
    end
    check("sum", sum, es);
    check("cout", cout, ec);
    check("ovf", ovf, eo);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_handoff", out_valid, 0);
    check("in_ready_after_handoff", in_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h0FCD, 1'b0, 0, 1'b0);
    check("dir_add", sum, 16'h2201);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
    run_op(16'hA5C3, 16'h1F2E, 1'b0, 10, 1'b1);

    // Reset during the second RUN cycle.
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_ovf", ovf, 0);
    @(posedge clk); #1;
    check("rst_no_valid", out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);
    check("post_rst_sum", sum, 16'h0002);

    for (int i = 0; i < 40; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
